// File: rtl/pe_window_feeder_pkg.sv
// rtl/pe_window_feeder_pkg.sv - shared types and constants for the PE window feeder
package pe_window_feeder_pkg;

   typedef enum logic [2:0] {
      IDLE,
      W_SETUP,
      W_PULSE,
      W_HOLD,
      PAD_HEAD,
      STREAM,
      PAD_TAIL,
      DONE
   } state_t;

   localparam int KERNEL_SIZE_DEF = 7;
   localparam int PAD             = (KERNEL_SIZE_DEF - 1) / 2;

   // window bit order: the newest sample lands at bit 0, the oldest at the top
   localparam int NEWEST_BIT = 0;

   function automatic int pad_of(input int k);
      return (k - 1) / 2;
   endfunction

endpackage

// File: rtl/pe_window_shreg.sv
// rtl/pe_window_shreg.sv - sliding-window shift register with saturating fill count
module pe_window_shreg
   import pe_window_feeder_pkg::*;
#(
   parameter int kernel_size = 7,
   parameter int FILL_W      = $clog2(kernel_size + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   shift_en,
   input  logic                   bit_in,
   output logic [kernel_size-1:0] window,
   output logic [FILL_W-1:0]      fill,
   output logic                   full
);

   assign full = (fill == FILL_W'(kernel_size));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         window <= '0;
         fill   <= '0;
      end else if (clear) begin
         window <= '0;
         fill   <= '0;
      end else if (shift_en) begin
         window <= (NEWEST_BIT == 0) ? {window[kernel_size-2:0], bit_in}
                                     : {bit_in, window[kernel_size-1:1]};
         if (!full)
            fill <= fill + FILL_W'(1);
      end
   end

endmodule

// File: rtl/pe_window_feeder.sv
// rtl/pe_window_feeder.sv - weight loader and padded sliding-window feeder for the binary PE
module pe_window_feeder
   import pe_window_feeder_pkg::*;
#(
   parameter int kernel_size = 7,
   parameter int SEQ_W       = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [kernel_size-1:0] weight_in,
   input  logic                   weight_valid,
   output logic                   weight_ready,
   input  logic                   start,
   input  logic [SEQ_W-1:0]       seq_len,
   input  logic                   pad_value,
   input  logic                   act_in,
   input  logic                   act_valid,
   output logic                   act_ready,
   output logic [kernel_size-1:0] weight_data,
   output logic                   new_weight_val,
   output logic [kernel_size-1:0] input_data,
   output logic                   window_valid,
   output logic [SEQ_W-1:0]       win_idx,
   output logic                   busy,
   output logic                   frame_done
);

   localparam int PAD_L  = pad_of(kernel_size);
   localparam int FILL_W = $clog2(kernel_size + 1);

   state_t             state, next_state;
   logic [SEQ_W-1:0]   seq_len_q;
   logic [SEQ_W-1:0]   cnt;
   logic               pad_q;
   logic               shift_en, shift_bit, clear_win, load_w;
   logic [FILL_W-1:0]  fill;
   logic               full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (weight_valid) next_state = W_SETUP;
                   else if (start)   next_state = PAD_HEAD;
         W_SETUP:  next_state = W_PULSE;
         W_PULSE:  next_state = W_HOLD;
         W_HOLD:   next_state = IDLE;
         PAD_HEAD: if (seq_len_q == '0)                  next_state = DONE;
                   else if (cnt == SEQ_W'(PAD_L - 1))    next_state = STREAM;
         STREAM:   if (act_valid && cnt == seq_len_q - SEQ_W'(1)) next_state = PAD_TAIL;
         PAD_TAIL: if (cnt == SEQ_W'(PAD_L - 1))         next_state = DONE;
         DONE:     next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   always_comb begin
      weight_ready = (state == IDLE) && !rst;
      act_ready    = (state == STREAM);
      load_w       = (state == IDLE) && weight_valid;
      clear_win    = (state == IDLE) && !weight_valid && start;
      shift_en     = ((state == PAD_HEAD) && (seq_len_q != '0)) ||
                     ((state == STREAM) && act_valid) ||
                     (state == PAD_TAIL);
      shift_bit    = (state == STREAM) ? act_in : pad_q;
   end

   pe_window_shreg #(
      .kernel_size (kernel_size),
      .FILL_W      (FILL_W)
   ) u_shreg (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear_win),
      .shift_en (shift_en),
      .bit_in   (shift_bit),
      .window   (input_data),
      .fill     (fill),
      .full     (full)
   );

   // cnt restarts on every state change, so it counts pad shifts or accepted bits per phase
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt            <= '0;
         seq_len_q      <= '0;
         pad_q          <= 1'b0;
         weight_data    <= '0;
         new_weight_val <= 1'b0;
         window_valid   <= 1'b0;
         win_idx        <= '0;
         busy           <= 1'b0;
         frame_done     <= 1'b0;
      end else begin
         if (next_state != state)
            cnt <= '0;
         else if (shift_en)
            cnt <= cnt + SEQ_W'(1);
         if (clear_win) begin
            seq_len_q <= seq_len;
            pad_q     <= pad_value;
         end
         if (load_w)
            weight_data <= weight_in;
         new_weight_val <= (next_state == W_PULSE);
         busy           <= (next_state != IDLE);
         frame_done     <= (next_state == DONE);
         window_valid   <= shift_en && (full || fill == FILL_W'(kernel_size - 1));
         if (clear_win)
            win_idx <= '0;
         else if (window_valid)
            win_idx <= win_idx + SEQ_W'(1);
      end
   end

endmodule

// File: tb/tb_pe_window_feeder.sv
// tb/tb_pe_window_feeder.sv - scoreboard bench for pe_window_feeder with kernel_size=7
module tb_pe_window_feeder;

   typedef struct packed {
      logic [6:0] win;
      logic [9:0] idx;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] weight_in;
   logic       weight_valid;
   logic       weight_ready;
   logic       start;
   logic [9:0] seq_len;
   logic       pad_value;
   logic       act_in;
   logic       act_valid;
   logic       act_ready;
   logic [6:0] weight_data;
   logic       new_weight_val;
   logic [6:0] input_data;
   logic       window_valid;
   logic [9:0] win_idx;
   logic       busy;
   logic       frame_done;

   exp_t sb[$];
   int   check_cnt = 0;
   int   pass_cnt  = 0;
   int   done_cnt  = 0;
   int   win_cnt   = 0;

   pe_window_feeder #(.kernel_size(7), .SEQ_W(10)) dut (
      .clk            (clk),
      .rst            (rst),
      .weight_in      (weight_in),
      .weight_valid   (weight_valid),
      .weight_ready   (weight_ready),
      .start          (start),
      .seq_len        (seq_len),
      .pad_value      (pad_value),
      .act_in         (act_in),
      .act_valid      (act_valid),
      .act_ready      (act_ready),
      .weight_data    (weight_data),
      .new_weight_val (new_weight_val),
      .input_data     (input_data),
      .window_valid   (window_valid),
      .win_idx        (win_idx),
      .busy           (busy),
      .frame_done     (frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // one clock: observe at the falling edge, return 1 time unit after the rising edge
   task automatic step();
      exp_t e;
      @(negedge clk);
      if (!rst) begin
         if (frame_done) done_cnt++;
         if (window_valid) begin
            win_cnt++;
            check_cnt++;
            if (sb.size() == 0)
               $display("FAIL window_unexpected: got win=%h idx=%0d, none expected", input_data, win_idx);
            else begin
               e = sb.pop_front();
               if (input_data !== e.win || win_idx !== e.idx)
                  $display("FAIL window: got win=%h idx=%0d, expected win=%h idx=%0d",
                           input_data, win_idx, e.win, e.idx);
               else
                  pass_cnt++;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] model_win(input int len, input logic pv, input logic [31:0] bits, input int i);
      logic [6:0] w;
      for (int k = 0; k < 7; k++) begin
         int j;
         j = i + 6 - k;
         if (j < 3 || j >= 3 + len) w[k] = pv;
         else                      w[k] = bits[j-3];
      end
      return w;
   endfunction

   task automatic push_model(input int len, input logic pv, input logic [31:0] bits);
      for (int i = 0; i < len; i++) sb.push_back({model_win(len, pv, bits, i), 10'(i)});
   endtask

   task automatic push_basic();
      sb.push_back({7'h0B, 10'd0});
      sb.push_back({7'h16, 10'd1});
      sb.push_back({7'h2C, 10'd2});
      sb.push_back({7'h58, 10'd3});
   endtask

   task automatic run_frame(input logic [9:0] len, input logic pv, input logic [31:0] bits,
                            input int stall_after, input int stall_len, input bit poke_start);
      int n;
      int d0;
      d0 = done_cnt;
      seq_len = len; pad_value = pv; start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (!act_ready && n < 20) begin step(); n++; end
      check_cnt++;
      if (act_ready !== 1'b1) $display("FAIL act_ready_wait: got %b, expected 1", act_ready);
      else pass_cnt++;
      for (int i = 0; i < int'(len); i++) begin
         act_in = bits[i]; act_valid = 1'b1;
         if (poke_start && i == 1) begin start = 1'b1; seq_len = 10'd2; end
         step();
         start = 1'b0;
         if (i + 1 == stall_after) begin
            act_valid = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
               step();
               check_cnt++;
               if (act_ready !== 1'b1 || window_valid !== 1'b0)
                  $display("FAIL stall: got act_ready=%b window_valid=%b, expected 1 and 0", act_ready, window_valid);
               else pass_cnt++;
            end
         end
      end
      act_valid = 1'b0;
      n = 0;
      while (done_cnt == d0 && n < 60) begin step(); n++; end
      step(); step();
      check_cnt++;
      if (done_cnt !== d0 + 1 || busy !== 1'b0 || sb.size() != 0)
         $display("FAIL frame_end: got done_pulses=%0d busy=%b pending=%0d, expected 1 0 0",
                  done_cnt - d0, busy, sb.size());
      else pass_cnt++;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      check_cnt++;
      if ({weight_data, new_weight_val, input_data, window_valid, win_idx, busy, frame_done, act_ready, weight_ready} !== '0)
         $display("FAIL reset_values: got wd=%h nwv=%b in=%h wv=%b idx=%0d busy=%b fd=%b ar=%b wr=%b, expected all 0",
                  weight_data, new_weight_val, input_data, window_valid, win_idx, busy, frame_done, act_ready, weight_ready);
      else pass_cnt++;
      rst = 1'b0;
      step();
      check_cnt++;
      if (weight_ready !== 1'b1 || busy !== 1'b0 || act_ready !== 1'b0)
         $display("FAIL reset_idle: got wr=%b busy=%b ar=%b, expected 1 0 0", weight_ready, busy, act_ready);
      else pass_cnt++;
   endtask

   task automatic test_weight_load();
      weight_in = 7'h55; weight_valid = 1'b1;
      step();
      weight_valid = 1'b0; weight_in = 7'h00;
      check_cnt++;
      if (weight_data !== 7'h55 || new_weight_val !== 1'b0 || weight_ready !== 1'b0)
         $display("FAIL wload_setup: got wd=%h nwv=%b wr=%b, expected 55 0 0", weight_data, new_weight_val, weight_ready);
      else pass_cnt++;
      step();
      check_cnt++;
      if (new_weight_val !== 1'b1 || weight_data !== 7'h55)
         $display("FAIL wload_pulse: got nwv=%b wd=%h, expected 1 55", new_weight_val, weight_data);
      else pass_cnt++;
      step();
      check_cnt++;
      if (new_weight_val !== 1'b0 || weight_data !== 7'h55 || weight_ready !== 1'b0)
         $display("FAIL wload_hold: got nwv=%b wd=%h wr=%b, expected 0 55 0", new_weight_val, weight_data, weight_ready);
      else pass_cnt++;
      step();
      check_cnt++;
      if (weight_ready !== 1'b1 || busy !== 1'b0 || weight_data !== 7'h55)
         $display("FAIL wload_idle: got wr=%b busy=%b wd=%h, expected 1 0 55", weight_ready, busy, weight_data);
      else pass_cnt++;
   endtask

   task automatic test_basic_frame();
      push_basic();
      run_frame(10'd4, 1'b0, 32'b1101, 0, 0, 1'b0);
   endtask

   task automatic test_stalls();
      push_basic();
      run_frame(10'd4, 1'b0, 32'b1101, 2, 3, 1'b0);
   endtask

   task automatic test_zero_len();
      int w0;
      int d0;
      w0 = win_cnt; d0 = done_cnt;
      seq_len = 10'd0; pad_value = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      check_cnt++;
      if (frame_done !== 1'b0 || busy !== 1'b1)
         $display("FAIL zero_len_head: got fd=%b busy=%b, expected 0 1", frame_done, busy);
      else pass_cnt++;
      step();
      check_cnt++;
      if (frame_done !== 1'b1)
         $display("FAIL zero_len_done: got fd=%b, expected 1", frame_done);
      else pass_cnt++;
      step(); step();
      check_cnt++;
      if (frame_done !== 1'b0 || busy !== 1'b0 || win_cnt != w0 || done_cnt != d0 + 1)
         $display("FAIL zero_len_end: got fd=%b busy=%b windows=%0d pulses=%0d, expected 0 0 0 1",
                  frame_done, busy, win_cnt - w0, done_cnt - d0);
      else pass_cnt++;
   endtask

   task automatic test_pad_one();
      sb.push_back({7'h77, 10'd0});
      run_frame(10'd1, 1'b1, 32'b0, 0, 0, 1'b0);
   endtask

   task automatic test_priority();
      int w0;
      int d0;
      w0 = win_cnt; d0 = done_cnt;
      weight_in = 7'h2A; weight_valid = 1'b1; start = 1'b1; seq_len = 10'd4;
      step();
      weight_valid = 1'b0; start = 1'b0;
      check_cnt++;
      if (weight_data !== 7'h2A || busy !== 1'b1)
         $display("FAIL priority_load: got wd=%h busy=%b, expected 2a 1", weight_data, busy);
      else pass_cnt++;
      repeat (4) step();
      check_cnt++;
      if (busy !== 1'b0 || weight_ready !== 1'b1 || win_cnt != w0 || done_cnt != d0)
         $display("FAIL priority_drop: got busy=%b wr=%b windows=%0d pulses=%0d, expected 0 1 0 0",
                  busy, weight_ready, win_cnt - w0, done_cnt - d0);
      else pass_cnt++;
   endtask

   task automatic test_start_ignored();
      push_basic();
      run_frame(10'd4, 1'b0, 32'b1101, 0, 0, 1'b1);
   endtask

   task automatic test_random_frame();
      logic [31:0] bits;
      logic        pv;
      bits = $urandom;
      pv   = 1'($urandom_range(1, 0));
      push_model(9, pv, bits);
      run_frame(10'd9, pv, bits, 5, 2, 1'b0);
   endtask

   task automatic test_midreset();
      int n;
      int w0;
      w0 = win_cnt;
      sb.push_back({7'h0B, 10'd0});
      sb.push_back({7'h16, 10'd1});
      seq_len = 10'd4; pad_value = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (!act_ready && n < 20) begin step(); n++; end
      for (int i = 0; i < 4; i++) begin
         act_in = (i == 1) ? 1'b0 : 1'b1; act_valid = 1'b1;
         step();
      end
      act_valid = 1'b0;
      n = 0;
      while (win_cnt < w0 + 2 && n < 20) begin step(); n++; end
      check_cnt++;
      if (win_cnt != w0 + 2 || sb.size() != 0)
         $display("FAIL midreset_windows: got %0d windows pending=%0d, expected 2 0", win_cnt - w0, sb.size());
      else pass_cnt++;
      #2 rst = 1'b1;
      #1;
      check_cnt++;
      if ({weight_data, new_weight_val, input_data, window_valid, win_idx, busy, frame_done, act_ready, weight_ready} !== '0)
         $display("FAIL midreset_zero: got wd=%h nwv=%b in=%h wv=%b idx=%0d busy=%b fd=%b ar=%b wr=%b, expected all 0",
                  weight_data, new_weight_val, input_data, window_valid, win_idx, busy, frame_done, act_ready, weight_ready);
      else pass_cnt++;
      sb.delete();
      step(); step();
      rst = 1'b0;
      step();
      push_basic();
      run_frame(10'd4, 1'b0, 32'b1101, 0, 0, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      weight_in = '0; weight_valid = 1'b0; start = 1'b0; seq_len = '0;
      pad_value = 1'b0; act_in = 1'b0; act_valid = 1'b0;
      test_reset();
      test_weight_load();
      test_basic_frame();
      test_stalls();
      test_zero_len();
      test_pad_one();
      test_priority();
      test_start_ignored();
      test_random_frame();
      test_midreset();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
